// File: rtl/fcl1_pkg.sv
// Shared definitions for the FCL layer-1 register/SRAM transfer paths:
// write-back FSM state encoding and the default geometry of the result bank.
package fcl1_pkg;

    localparam int NUM_FILTER = 6;
    localparam int RAM_DEPTH  = 5;
    localparam int RAM_ADDRW  = 3;
    localparam int RAM_WIDTH  = 40;
    localparam int CNT_WIDTH  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/reg_to_sram_write_if.sv
// Register-bank / SRAM write-port bundle of the layer-1 write-back path.
// master drives start, bank and ready; slave (the write-back block) drives the SRAM side.
interface reg_to_sram_write_if #(
    parameter int RAM_DEPTH = fcl1_pkg::RAM_DEPTH,
    parameter int RAM_ADDRW = fcl1_pkg::RAM_ADDRW,
    parameter int RAM_WIDTH = fcl1_pkg::RAM_WIDTH
);

    logic                           sram_write_en_i;
    logic [RAM_DEPTH*RAM_WIDTH-1:0] sram_write_reg_data_i;
    logic                           sram_write_ready_i;
    logic                           sram_write_we_o;
    logic [RAM_ADDRW-1:0]           sram_write_addr_o;
    logic [RAM_WIDTH-1:0]           sram_write_data_o;
    logic                           sram_write_busy_o;
    logic                           sram_write_cnt_done_o;

    modport master (
        output sram_write_en_i, sram_write_reg_data_i, sram_write_ready_i,
        input  sram_write_we_o, sram_write_addr_o, sram_write_data_o,
               sram_write_busy_o, sram_write_cnt_done_o
    );

    modport slave (
        input  sram_write_en_i, sram_write_reg_data_i, sram_write_ready_i,
        output sram_write_we_o, sram_write_addr_o, sram_write_data_o,
               sram_write_busy_o, sram_write_cnt_done_o
    );

endinterface

// File: rtl/wr_word_counter.sv
// Word index of the write-back transfer: clear wins over enable, and the
// terminal flag marks the last word of the bank.
module wr_word_counter #(
    parameter int CNT_WIDTH = fcl1_pkg::CNT_WIDTH,
    parameter int RAM_DEPTH = fcl1_pkg::RAM_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_WIDTH'(RAM_DEPTH - 1));

endmodule

// File: rtl/reg_to_sram_write.sv
// Layer-1 write-back: snapshots the result register bank on a rising start
// and streams it word by word into the result SRAM, honouring SRAM ready.
module reg_to_sram_write
    import fcl1_pkg::*;
#(
    parameter int CNT_WIDTH = fcl1_pkg::CNT_WIDTH,
    parameter int RAM_DEPTH = fcl1_pkg::RAM_DEPTH,
    parameter int RAM_ADDRW = fcl1_pkg::RAM_ADDRW,
    parameter int RAM_WIDTH = fcl1_pkg::RAM_WIDTH
) (
    input  logic                sram_write_clk,
    input  logic                sram_write_rst,
    reg_to_sram_write_if.slave  bus
);

    wr_state_e             state_q;
    logic                  en_q;
    logic                  we_q;
    logic [RAM_ADDRW-1:0]  addr_q;
    logic [RAM_WIDTH-1:0]  data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [RAM_WIDTH-1:0]  bank_q [RAM_DEPTH];

    logic                  start;
    logic                  clr;
    logic                  accept;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  nxt_idx;
    logic                  cnt_last;

    assign start   = bus.sram_write_en_i & ~en_q;
    assign clr     = (state_q == IDLE) & start;
    assign accept  = (state_q == WRITE) & we_q & bus.sram_write_ready_i;
    assign nxt_idx = cnt + CNT_WIDTH'(1);

    wr_word_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_cnt (
        .clk    (sram_write_clk),
        .rst    (sram_write_rst),
        .clr_i  (clr),
        .en_i   (accept),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // The snapshot is pure data storage; only the control path needs reset.
    always_ff @(posedge sram_write_clk) begin
        if (clr) begin
            for (int k = 0; k < RAM_DEPTH; k++) begin
                bank_q[k] <= bus.sram_write_reg_data_i[k*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    always_ff @(posedge sram_write_clk) begin
        if (sram_write_rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            en_q   <= bus.sram_write_en_i;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Word 0 comes straight from the bank input; the snapshot lands this same edge.
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= bus.sram_write_reg_data_i[0 +: RAM_WIDTH];
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (cnt_last) begin
                            state_q <= DONE;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= RAM_ADDRW'(nxt_idx);
                            data_q <= bank_q[nxt_idx];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sram_write_we_o       = we_q;
    assign bus.sram_write_addr_o     = addr_q;
    assign bus.sram_write_data_o     = data_q;
    assign bus.sram_write_busy_o     = busy_q;
    assign bus.sram_write_cnt_done_o = done_q;

endmodule

// File: tb/tb_reg_to_sram_write.sv
// Directed bench for reg_to_sram_write: per-cycle vector table for the basic,
// held-start and stall transfers, plus sequences for snapshot and reset cases.
module tb_reg_to_sram_write;

    localparam int W  = 40;
    localparam int D  = 5;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_to_sram_write_if #(.RAM_DEPTH(D), .RAM_ADDRW(AW), .RAM_WIDTH(W)) bus ();

    reg_to_sram_write #(
        .CNT_WIDTH (3),
        .RAM_DEPTH (D),
        .RAM_ADDRW (AW),
        .RAM_WIDTH (W)
    ) dut (
        .sram_write_clk (clk),
        .sram_write_rst (rst),
        .bus            (bus)
    );

    typedef struct {
        bit en;
        bit rdy;
        bit we;
        int addr;
        bit busy;
        bit done;
    } vec_t;

    vec_t tbl [20];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input bit we, input int addr,
                             input logic [W-1:0] data, input bit busy, input bit done,
                             input bit chk_ad);
        cmp({tag, ".we"},   64'(bus.sram_write_we_o),       64'(we));
        cmp({tag, ".busy"}, 64'(bus.sram_write_busy_o),     64'(busy));
        cmp({tag, ".done"}, 64'(bus.sram_write_cnt_done_o), 64'(done));
        if (chk_ad) begin
            cmp({tag, ".addr"}, 64'(bus.sram_write_addr_o), 64'(addr));
            cmp({tag, ".data"}, 64'(bus.sram_write_data_o), 64'(data));
        end
    endtask

    function automatic logic [D*W-1:0] pattern(input logic [W-1:0] base);
        logic [D*W-1:0] p;
        for (int k = 0; k < D; k++) begin
            p[k*W +: W] = base + W'(k);
        end
        return p;
    endfunction

    task automatic setv(input int i, input bit en, input bit rdy, input bit we,
                        input int addr, input bit busy, input bit done);
        tbl[i].en   = en;
        tbl[i].rdy  = rdy;
        tbl[i].we   = we;
        tbl[i].addr = addr;
        tbl[i].busy = busy;
        tbl[i].done = done;
    endtask

    initial begin
        int n_we;
        int n_done;
        logic [W-1:0] base;

        // basic transfer with en held high afterwards (rows 0-8)
        setv(0,  1, 1, 1, 0, 1, 0);
        setv(1,  1, 1, 1, 1, 1, 0);
        setv(2,  1, 1, 1, 2, 1, 0);
        setv(3,  1, 1, 1, 3, 1, 0);
        setv(4,  1, 1, 1, 4, 1, 0);
        setv(5,  1, 1, 0, 0, 1, 1);
        setv(6,  1, 1, 0, 0, 0, 0);
        setv(7,  1, 1, 0, 0, 0, 0);
        setv(8,  0, 1, 0, 0, 0, 0);
        // stall at addr 2 for 3 cycles, en toggled mid-transfer (rows 9-19)
        setv(9,  1, 1, 1, 0, 1, 0);
        setv(10, 1, 1, 1, 1, 1, 0);
        setv(11, 1, 1, 1, 2, 1, 0);
        setv(12, 0, 0, 1, 2, 1, 0);
        setv(13, 1, 0, 1, 2, 1, 0);
        setv(14, 1, 0, 1, 2, 1, 0);
        setv(15, 1, 1, 1, 3, 1, 0);
        setv(16, 1, 1, 1, 4, 1, 0);
        setv(17, 1, 1, 0, 0, 1, 1);
        setv(18, 1, 1, 0, 0, 0, 0);
        setv(19, 0, 1, 0, 0, 0, 0);

        rst = 1'b1;
        bus.sram_write_en_i       = 1'b0;
        bus.sram_write_ready_i    = 1'b1;
        bus.sram_write_reg_data_i = pattern(40'h00_0000_0010);
        tick();
        tick();
        check_out("reset", 0, 0, '0, 0, 0, 1);
        rst = 1'b0;
        tick();
        check_out("idle", 0, 0, '0, 0, 0, 1);

        for (int i = 0; i < 20; i++) begin
            bus.sram_write_en_i    = tbl[i].en;
            bus.sram_write_ready_i = tbl[i].rdy;
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr,
                      40'h10 + W'(tbl[i].addr), tbl[i].busy, tbl[i].done, tbl[i].we);
        end

        // snapshot: bank overwritten with all ones right after the start edge
        base = 40'h12_3456_7800;
        bus.sram_write_reg_data_i = pattern(base);
        bus.sram_write_en_i = 1'b1;
        tick();
        bus.sram_write_reg_data_i = '1;
        check_out("snap0", 1, 0, base, 1, 0, 1);
        for (int k = 1; k < D; k++) begin
            tick();
            check_out($sformatf("snap%0d", k), 1, k, base + W'(k), 1, 0, 1);
        end
        tick();
        check_out("snap_done", 0, 0, '0, 1, 1, 0);
        bus.sram_write_en_i = 1'b0;
        bus.sram_write_reg_data_i = pattern(40'h00_0000_0010);
        tick();

        // en held high for 20 cycles: exactly one transfer
        n_we = 0;
        n_done = 0;
        bus.sram_write_en_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_we   += int'(bus.sram_write_we_o);
            n_done += int'(bus.sram_write_cnt_done_o);
        end
        cmp("held.we_cycles", 64'(n_we), 64'(5));
        cmp("held.done_pulses", 64'(n_done), 64'(1));
        bus.sram_write_en_i = 1'b0;
        tick();

        // reset while addr 3 is on the bus
        bus.sram_write_en_i = 1'b1;
        tick();
        for (int k = 1; k < 4; k++) tick();
        check_out("pre_rst", 1, 3, 40'h13, 1, 0, 1);
        rst = 1'b1;
        bus.sram_write_en_i = 1'b0;
        tick();
        check_out("mid_rst", 0, 0, '0, 0, 0, 1);
        rst = 1'b0;
        n_we = 0;
        n_done = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_we   += int'(bus.sram_write_we_o);
            n_done += int'(bus.sram_write_cnt_done_o);
        end
        cmp("after_rst.we_cycles", 64'(n_we), 64'(0));
        cmp("after_rst.done_pulses", 64'(n_done), 64'(0));
        bus.sram_write_en_i = 1'b1;
        tick();
        check_out("restart0", 1, 0, 40'h10, 1, 0, 1);
        for (int k = 1; k < D; k++) tick();
        check_out("restart4", 1, 4, 40'h14, 1, 0, 1);
        tick();
        check_out("restart_done", 0, 0, '0, 1, 1, 0);
        bus.sram_write_en_i = 1'b0;
        tick();

        // reset released with en already high counts as a start
        rst = 1'b1;
        bus.sram_write_en_i = 1'b1;
        tick();
        check_out("rst_en", 0, 0, '0, 0, 0, 1);
        rst = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t < 6) begin
                check_out($sformatf("rel%0d", t), 1, t - 1, 40'h10 + W'(t - 1), 1, 0, 1);
            end else begin
                check_out("rel_done", 0, 0, '0, 1, 1, 0);
            end
        end
        bus.sram_write_en_i = 1'b0;
        tick();
        check_out("final_idle", 0, 0, '0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
